// File: rtl/pc_sel_pkg.sv
// pc_sel_pkg: shared encodings and default vectors for the next-PC unit
package pc_sel_pkg;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_JR   = 2'b01,
        JMP_JAL  = 2'b10,
        JMP_J    = 2'b11
    } jump_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_RSVD = 2'b11
    } branch_e;

    localparam int unsigned RESET_PC_DEF = 32'h0;
    localparam int unsigned EXC_VEC_DEF  = 32'h20;

endpackage

// File: rtl/pc_select_unit_ras.sv
// ras_stack: circular return-address stack; pushes past full overwrite the oldest entry
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;

    // ptr is the next write slot, so the top lives one below it
    assign top   = mem[ptr - PW'(1)];
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr   <= ptr + PW'(1);
            count <= full ? count : count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= din;
    end

endmodule

// File: rtl/pc_select_unit.sv
// pc_select_unit: fetch PC register with branch/jump/exception redirects,
// stall-tolerant redirect buffering and an optional return-address stack.
module pc_select_unit
    import pc_sel_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              JIDX_W    = 26,
    parameter int              RAS_DEPTH = 4,
    parameter bit              USE_RAS   = 1'b1,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(EXC_VEC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              id_valid,
    input  logic [1:0]        branch,
    input  logic [1:0]        jump,
    input  logic              equal,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] br_off,
    input  logic [JIDX_W-1:0] j_idx,
    input  logic [ADDR_W-1:0] jr_tgt,
    input  logic              exc_req,
    output logic [ADDR_W-1:0] pc,
    output logic              flush,
    output logic              redirect_pending,
    output logic              ras_empty,
    output logic              ras_full
);
    jump_e             jmp;
    branch_e           br;
    logic              take;
    logic              accept;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pend_tgt;
    logic [ADDR_W-1:0] ras_top;

    assign jmp = jump_e'(jump);
    assign br  = branch_e'(branch);

    assign take = id_valid && (jmp != JMP_NONE || (br == BR_BEQ && equal) || (br == BR_BNE && !equal));

    always_comb begin
        target = id_pc + br_off + ADDR_W'(1);
        if (jmp == JMP_J || jmp == JMP_JAL)
            target = {id_pc[ADDR_W-1:JIDX_W], j_idx};
        else if (jmp == JMP_JR)
            target = (USE_RAS && !ras_empty) ? ras_top : jr_tgt;
    end

    // A stalled ID instruction is accepted once; its RAS effect happens then
    assign accept = take && !exc_req && !redirect_pending;

    ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && jmp == JMP_JAL),
        .pop   (accept && jmp == JMP_JR),
        .din   (id_pc + ADDR_W'(1)),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc               <= RESET_PC;
            flush            <= 1'b0;
            redirect_pending <= 1'b0;
            pend_tgt         <= '0;
        end else if (exc_req) begin
            pc               <= EXC_VEC;
            flush            <= 1'b1;
            redirect_pending <= 1'b0;
        end else if (redirect_pending) begin
            pc               <= stall ? pc : pend_tgt;
            flush            <= !stall;
            redirect_pending <= stall;
        end else if (take) begin
            pc               <= stall ? pc : target;
            pend_tgt         <= target;
            flush            <= !stall;
            redirect_pending <= stall;
        end else begin
            pc               <= stall ? pc : pc + ADDR_W'(1);
            flush            <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_select_unit.sv
// tb_pc_select_unit: directed vector table plus hand sequences for the next-PC unit
module tb_pc_select_unit;

    typedef struct {
        logic        rst, stall, idv;
        logic [1:0]  br, jp;
        logic        eq;
        logic [31:0] id_pc, off;
        logic [25:0] jix;
        logic [31:0] jrt;
        logic        exc;
        logic [31:0] e_pc;
        logic        e_fl, e_pd, e_em, e_fu;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0, stall = 1'b0, id_valid = 1'b0, equal = 1'b0, exc_req = 1'b0;
    logic [1:0]  branch = '0, jump = '0;
    logic [31:0] id_pc = '0, br_off = '0, jr_tgt = '0;
    logic [25:0] j_idx = '0;
    logic [31:0] pc;
    logic        flush, redirect_pending, ras_empty, ras_full;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    always #5 clk = ~clk;

    pc_select_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .id_valid         (id_valid),
        .branch           (branch),
        .jump             (jump),
        .equal            (equal),
        .id_pc            (id_pc),
        .br_off           (br_off),
        .j_idx            (j_idx),
        .jr_tgt           (jr_tgt),
        .exc_req          (exc_req),
        .pc               (pc),
        .flush            (flush),
        .redirect_pending (redirect_pending),
        .ras_empty        (ras_empty),
        .ras_full         (ras_full)
    );

    function automatic vec_t v(logic r, logic s, logic i, logic [1:0] b, logic [1:0] j, logic e,
                               logic [31:0] ip, logic [31:0] o, logic [25:0] x, logic [31:0] t,
                               logic ex, logic [31:0] p, logic fl, logic pd, logic em, logic fu);
        vec_t q;
        q.rst = r; q.stall = s; q.idv = i; q.br = b; q.jp = j; q.eq = e;
        q.id_pc = ip; q.off = o; q.jix = x; q.jrt = t; q.exc = ex;
        q.e_pc = p; q.e_fl = fl; q.e_pd = pd; q.e_em = em; q.e_fu = fu;
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    task automatic apply(input vec_t q);
        @(negedge clk);
        rst = q.rst; stall = q.stall; id_valid = q.idv; branch = q.br; jump = q.jp;
        equal = q.eq; id_pc = q.id_pc; br_off = q.off; j_idx = q.jix; jr_tgt = q.jrt;
        exc_req = q.exc;
        @(posedge clk);
        #1;
        chk("pc", pc, q.e_pc);
        chk("flush", 32'(flush), 32'(q.e_fl));
        chk("pending", 32'(redirect_pending), 32'(q.e_pd));
        chk("ras_empty", 32'(ras_empty), 32'(q.e_em));
        chk("ras_full", 32'(ras_full), 32'(q.e_fu));
        step_no++;
    endtask

    vec_t tbl [35];
    vec_t h;

    initial begin
        //            rst stl idv br    jp    eq ip            off           jix       jrt        exc  pc            fl pd em fu
        tbl[0]  = v(1, 0, 0, 2'b00, 2'b00, 0, 32'h0,        32'h0,        26'h0,   32'h0,     0,   32'h0,        0, 0, 1, 0);
        tbl[1]  = v(0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        32'h0,        26'h0,   32'h0,     0,   32'h1,        0, 0, 1, 0);
        tbl[2]  = v(0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        32'h0,        26'h0,   32'h0,     0,   32'h2,        0, 0, 1, 0);
        tbl[3]  = v(0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        32'h0,        26'h0,   32'h0,     0,   32'h3,        0, 0, 1, 0);
        tbl[4]  = v(0, 0, 1, 2'b01, 2'b00, 1, 32'd10,       32'd5,        26'h0,   32'h0,     0,   32'd16,       1, 0, 1, 0);
        tbl[5]  = v(0, 0, 1, 2'b01, 2'b00, 0, 32'd10,       32'd5,        26'h0,   32'h0,     0,   32'd17,       0, 0, 1, 0);
        tbl[6]  = v(0, 1, 1, 2'b10, 2'b00, 0, 32'd10,       32'hFFFFFFFD, 26'h0,   32'h0,     0,   32'd17,       0, 1, 1, 0);
        tbl[7]  = v(0, 1, 1, 2'b10, 2'b00, 0, 32'd10,       32'hFFFFFFFD, 26'h0,   32'h0,     0,   32'd17,       0, 1, 1, 0);
        tbl[8]  = v(0, 0, 1, 2'b10, 2'b00, 0, 32'd10,       32'hFFFFFFFD, 26'h0,   32'h0,     0,   32'd8,        1, 0, 1, 0);
        tbl[9]  = v(0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        32'h0,        26'h0,   32'h0,     0,   32'd9,        0, 0, 1, 0);
        tbl[10] = v(0, 0, 1, 2'b00, 2'b10, 0, 32'h40,       32'h0,        26'h123, 32'h0,     0,   32'h123,      1, 0, 0, 0);
        tbl[11] = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0,        32'h0,        26'h0,   32'h99,    0,   32'h41,       1, 0, 1, 0);
        tbl[12] = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0,        32'h0,        26'h0,   32'h99,    0,   32'h99,       1, 0, 1, 0);
        tbl[13] = v(0, 0, 1, 2'b00, 2'b11, 0, 32'hFC000000, 32'h0,        26'h5,   32'h0,     0,   32'hFC000005, 1, 0, 1, 0);
        tbl[14] = v(0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        32'h0,        26'h0,   32'h0,     0,   32'hFC000006, 0, 0, 1, 0);
        tbl[15] = v(0, 0, 1, 2'b00, 2'b10, 0, 32'd0,        32'h0,        26'h200, 32'h0,     0,   32'h200,      1, 0, 0, 0);
        tbl[16] = v(0, 0, 1, 2'b00, 2'b10, 0, 32'd1,        32'h0,        26'h200, 32'h0,     0,   32'h200,      1, 0, 0, 0);
        tbl[17] = v(0, 0, 1, 2'b00, 2'b10, 0, 32'd2,        32'h0,        26'h200, 32'h0,     0,   32'h200,      1, 0, 0, 0);
        tbl[18] = v(0, 0, 1, 2'b00, 2'b10, 0, 32'd3,        32'h0,        26'h200, 32'h0,     0,   32'h200,      1, 0, 0, 1);
        tbl[19] = v(0, 0, 1, 2'b00, 2'b10, 0, 32'd4,        32'h0,        26'h200, 32'h0,     0,   32'h200,      1, 0, 0, 1);
        tbl[20] = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0,        32'h0,        26'h0,   32'h77,    0,   32'd5,        1, 0, 0, 0);
        tbl[21] = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0,        32'h0,        26'h0,   32'h77,    0,   32'd4,        1, 0, 0, 0);
        tbl[22] = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0,        32'h0,        26'h0,   32'h77,    0,   32'd3,        1, 0, 0, 0);
        tbl[23] = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0,        32'h0,        26'h0,   32'h77,    0,   32'd2,        1, 0, 1, 0);
        tbl[24] = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0,        32'h0,        26'h0,   32'h77,    0,   32'h77,       1, 0, 1, 0);
        tbl[25] = v(0, 1, 1, 2'b00, 2'b10, 0, 32'h10,       32'h0,        26'h300, 32'h0,     0,   32'h77,       0, 1, 0, 0);
        tbl[26] = v(0, 1, 1, 2'b00, 2'b11, 0, 32'h0,        32'h0,        26'h300, 32'h0,     1,   32'h20,       1, 0, 0, 0);
        tbl[27] = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0,        32'h0,        26'h0,   32'h55,    1,   32'h20,       1, 0, 0, 0);
        tbl[28] = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0,        32'h0,        26'h0,   32'h55,    0,   32'h11,       1, 0, 1, 0);
        tbl[29] = v(0, 0, 1, 2'b01, 2'b00, 1, 32'hFFFFFFFF, 32'h0,        26'h0,   32'h0,     0,   32'h0,        1, 0, 1, 0);
        tbl[30] = v(0, 0, 1, 2'b11, 2'b00, 1, 32'h0,        32'h0,        26'h0,   32'h0,     0,   32'h1,        0, 0, 1, 0);
        tbl[31] = v(0, 0, 0, 2'b00, 2'b10, 0, 32'h50,       32'h0,        26'h300, 32'h0,     0,   32'h2,        0, 0, 1, 0);
        tbl[32] = v(0, 1, 1, 2'b01, 2'b00, 1, 32'h100,      32'h2,        26'h0,   32'h0,     0,   32'h2,        0, 1, 1, 0);
        tbl[33] = v(1, 1, 1, 2'b01, 2'b00, 1, 32'h100,      32'h2,        26'h0,   32'h0,     0,   32'h0,        0, 0, 1, 0);
        tbl[34] = v(0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        32'h0,        26'h0,   32'h0,     0,   32'h1,        0, 0, 1, 0);
        for (int i = 0; i < 35; i++) apply(tbl[i]);
        // jal held in a multi-cycle stall must push exactly once
        h = v(0, 1, 1, 2'b00, 2'b10, 0, 32'h30, 32'h0, 26'h400, 32'h0, 0, 32'h1, 0, 1, 0, 0);
        apply(h);
        apply(h);
        h.stall = 0; h.e_pc = 32'h400; h.e_fl = 1; h.e_pd = 0;
        apply(h);
        h = v(0, 0, 1, 2'b00, 2'b01, 0, 32'h0, 32'h0, 26'h0, 32'hAA, 0, 32'h31, 1, 0, 1, 0);
        apply(h);
        h = v(0, 0, 0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h32, 0, 0, 1, 0);
        apply(h);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_select_unit.md
Name: pc_select_unit

Overview:
Next-generation next-PC unit for the MIPS pipeline. It owns the fetch PC register and resolves jump/branch redirects from ID using the existing Branch/Jump/Equal encoding, on word-addressed PCs. New over the previous generation: parametrised widths, stall-tolerant redirect buffering, an exception vector, a registered flush pulse, and an optional return-address stack (RAS) for jal/jr.

Parameters:
ADDR_W, 32, PC/target width in words
JIDX_W, 26, j/jal index width; must be < ADDR_W
RAS_DEPTH, 4, return-address stack entries; power of 2, >= 2
USE_RAS, 1, 1: jr takes its target from the RAS top when the RAS is non-empty; 0: jr always uses jr_tgt
RESET_PC, 0, PC value loaded at reset
EXC_VEC, 'h20, PC value loaded on exc_req

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  freeze fetch PC (hazard)
id_valid  in  1  ID-stage resolution inputs valid
branch  in  2  00 none, 01 beq, 10 bne, 11 reserved (never taken)
jump  in  2  11 j, 10 jal, 01 jr, 00 none
equal  in  1  ID comparator result
id_pc  in  ADDR_W  PC of the instruction in ID
br_off  in  ADDR_W  sign-extended branch offset (words)
j_idx  in  JIDX_W  jump index field
jr_tgt  in  ADDR_W  register-file jr target
exc_req  in  1  exception redirect request
pc  out  ADDR_W  fetch PC register
flush  out  1  one-cycle pulse: IF/ID holds a wrong-path instruction
redirect_pending  out  1  redirect is latched and waiting for stall to drop
ras_empty  out  1  RAS empty
ras_full  out  1  RAS full

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, flush=0, redirect_pending=0, RAS count=0, RAS pointer=0. Reset overrides every other input, including mid-pending.
- take (combinational) = id_valid & (jump!=00 | (branch==01 & equal) | (branch==10 & ~equal)). jump has priority over branch.
- Target selection:
  - j / jal: {id_pc[ADDR_W-1:JIDX_W], j_idx}
  - jr: RAS top if USE_RAS and ~ras_empty; otherwise jr_tgt
  - branch: id_pc + br_off + 1, computed modulo 2^ADDR_W so wrap-around is silent
- Edge priority:
  1. exc_req: pc<=EXC_VEC, clear pending, flush<=1. Any RAS op this cycle is suppressed.
  2. redirect_pending & ~stall: pc<=pend_tgt, pending<=0, flush<=1.
  3. redirect_pending & stall: hold everything. A new take is ignored, because it is the same stalled ID instruction.
  4. take & ~stall: pc<=target, flush<=1.
  5. take & stall: pend_tgt<=target, pending<=1, pc held, flush<=0.
  6. ~stall: pc<=pc+1 (wraps); otherwise hold. flush<=0.
- Redirect latency: one cycle when not stalled. flush is high exactly one cycle after each pc redirect load.
- RAS operations occur only when a jal/jr take is accepted (cases 4 or 5), so each instruction acts at most once:
  - jal pushes id_pc+1.
  - jr pops.
- RAS boundaries:
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change; jr_tgt is used.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are registered-state derived.
- USE_RAS=0: RAS logic is still present, but the jr target is always jr_tgt.

Decomposition:
- Package pc_sel_pkg holds:
  - jump_e: J=2'b11, JAL=2'b10, JR=2'b01, NONE=2'b00
  - branch_e: NONE, BEQ, BNE, RSVD
  - shared constants RESET_PC_DEF and EXC_VEC_DEF
- One sub-module: ras_stack (push, pop, top, empty, full; parameters DEPTH and W), circular with a saturating count.

Test Plan:
- Reset, then 3 cycles with no stall: pc = 0,1,2,3; flush=0; ras_empty=1.
- beq: id_pc=10, br_off=5, equal=1, no stall -> next pc=16, flush=1 one cycle later. Same inputs with equal=0 -> pc increments normally.
- bne taken (id_pc=10, br_off=-3, equal=0) with stall=1 for 2 cycles:
  - redirect_pending=1 and pc held for those cycles.
  - Cycle after stall drops: pc=8 and flush=1.
- RAS sequence with USE_RAS=1:
  - jal id_pc=0x40 -> pc={id_pc top bits, j_idx}.
  - jr with jr_tgt=0x99 -> pc=0x41.
  - Second jr on the now-empty RAS -> pc=0x99.
- Overflow with RAS_DEPTH=4: 5 jal pushes (returns 1..5), then 5 jr pops -> targets 5,4,3,2, then jr_tgt; ras_full=1 after the 4th push.
- Simultaneous events and reset:
  - exc_req together with taken j while pending -> pc=EXC_VEC, pending=0, RAS count unchanged.
  - rst asserted with pending=1 -> pc=RESET_PC, pending=0.
